exp5_unidade_controle_rodadas: RTL

Moore-machine control unit for the round-based memory game. It sequences the experiment datapath: address counter (E), round-limit counter (L), play register (R) and timeout counter (T). Round n requires the player to repeat stored entries 0..n. The block reports win, loss-by-error or loss-by-timeout, plus a 4-bit state code for the hex debug display.

---
 rtl/exp5_unidade_controle_rodadas.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/exp5_unidade_controle_rodadas.sv
// Purpose: Moore control FSM for the round-based memory game (sequences counters E/L/T and play register R).
// Latency: one state per rising edge; outputs decode from the registered state only, so they change only after an edge.
// Backpressure: none; the datapath flags are sampled every cycle and the block never stalls its inputs.
module exp5_unidade_controle_rodadas (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       jogada_i,
    input  logic       igual_i,
    input  logic       fimE_i,
    input  logic       fimL_i,
    input  logic       fimT_i,
    output logic       zeraE_o,
    output logic       contaE_o,
    output logic       zeraL_o,
    output logic       contaL_o,
    output logic       zeraR_o,
    output logic       registraR_o,
    output logic       zeraT_o,
    output logic       contaT_o,
    output logic       acertou_o,
    output logic       errou_o,
    output logic       timeout_o,
    output logic       pronto_o,
    output logic [3:0] db_estado_o
);

    // Encodings double as the hex debug code shown on the display.
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;

    // State register; synchronous reset overrides every transition.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; unreachable encodings recover to inicial.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = iniciar_i ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIA_RODADA;
            INICIA_RODADA:  estado_d = ESPERA;
            // A play in the same cycle as the timeout wins.
            ESPERA: begin
                if (jogada_i) begin
                    estado_d = REGISTRA;
                end else if (fimT_i) begin
                    estado_d = FIM_TIMEOUT;
                end else begin
                    estado_d = ESPERA;
                end
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual_i) begin
                    estado_d = FIM_ERRO;
                end else if (!fimE_i) begin
                    estado_d = PROXIMO;
                end else if (!fimL_i) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = FIM_ACERTO;
                end
            end
            PROXIMO:        estado_d = ESPERA;
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            // Restart always goes through preparacao so the datapath is cleared.
            FIM_ACERTO:     estado_d = iniciar_i ? PREPARACAO : FIM_ACERTO;
            FIM_TIMEOUT:    estado_d = iniciar_i ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERRO:       estado_d = iniciar_i ? PREPARACAO : FIM_ERRO;
            default:        estado_d = INICIAL;
        endcase
    end

    // Moore output decode from the current state.
    always_comb begin
        zeraE_o     = 1'b0;
        contaE_o    = 1'b0;
        zeraL_o     = 1'b0;
        contaL_o    = 1'b0;
        zeraR_o     = 1'b0;
        registraR_o = 1'b0;
        zeraT_o     = 1'b0;
        contaT_o    = 1'b0;
        acertou_o   = 1'b0;
        errou_o     = 1'b0;
        timeout_o   = 1'b0;
        pronto_o    = 1'b0;
        db_estado_o = 4'hF;
        case (estado_q)
            INICIAL: begin
                zeraE_o     = 1'b1;
                zeraL_o     = 1'b1;
                zeraR_o     = 1'b1;
                zeraT_o     = 1'b1;
                db_estado_o = 4'h0;
            end
            PREPARACAO: begin
                zeraE_o     = 1'b1;
                zeraL_o     = 1'b1;
                zeraR_o     = 1'b1;
                zeraT_o     = 1'b1;
                db_estado_o = 4'h1;
            end
            INICIA_RODADA: begin
                zeraE_o     = 1'b1;
                zeraT_o     = 1'b1;
                db_estado_o = 4'h2;
            end
            ESPERA: begin
                contaT_o    = 1'b1;
                db_estado_o = 4'h3;
            end
            REGISTRA: begin
                registraR_o = 1'b1;
                zeraT_o     = 1'b1;
                db_estado_o = 4'h4;
            end
            COMPARACAO: begin
                db_estado_o = 4'h5;
            end
            PROXIMO: begin
                contaE_o    = 1'b1;
                zeraT_o     = 1'b1;
                db_estado_o = 4'h6;
            end
            PROXIMA_RODADA: begin
                contaL_o    = 1'b1;
                db_estado_o = 4'h7;
            end
            FIM_ACERTO: begin
                acertou_o   = 1'b1;
                pronto_o    = 1'b1;
                db_estado_o = 4'hA;
            end
            FIM_TIMEOUT: begin
                timeout_o   = 1'b1;
                pronto_o    = 1'b1;
                db_estado_o = 4'hD;
            end
            FIM_ERRO: begin
                errou_o     = 1'b1;
                pronto_o    = 1'b1;
                db_estado_o = 4'hE;
            end
            default: begin
                db_estado_o = 4'hF;
            end
        endcase
    end

endmodule
